// File: rtl/alu_seq_if.sv
// alu_seq_if: request/result bundle for the sequential ALU.
//   master : drives start, in1, in2, shamt, control; observes busy, done, out, flag
//   slave  : the ALU side (alu_seq)
interface alu_seq_if #(
  parameter int WIDTH = 32,
  parameter int SH    = 5
);
  logic             start;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [SH-1:0]    shamt;
  logic [3:0]       control;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic [3:0]       flag;

  modport master (
    output start, in1, in2, shamt, control,
    input  busy, done, out, flag
  );

  modport slave (
    input  start, in1, in2, shamt, control,
    output busy, done, out, flag
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with add/negate/sub/and/xor and three shifts.
//
// Ports:
//   clk   - single clock, all state on rising edge
//   rst_n - asynchronous active-low reset
//   bus   - alu_seq_if.slave: start/in1/in2/shamt/control in,
//           busy/done/out/flag out
//
// control[2:0] opcode: 000 add, 001 negate, 010 sub, 011 and, 100 xor,
//                      101 sll, 110 srl, 111 sra
// control[3]   shift amount source: 0 = shamt, 1 = in2[SH-1:0]
// flag         [0] zero, [1] msb, [2] carry / no-borrow, [3] signed overflow
//
// Build option ALU_SEQ_BARREL_EN: when defined, shifts complete in one cycle
// through EXEC with a barrel shifter; otherwise they shift one bit per cycle
// in SHIFT.
//
// state | meaning
// IDLE  | waiting for start, busy=0
// EXEC  | single-cycle op (all ops when barrel shifter is built)
// SHIFT | iterative shift, cnt_q bit positions left to go
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SH    = 5
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_seq_if.slave  bus
);

  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [SH-1:0]    CNT_ONE = {{(SH-1){1'b0}}, 1'b1};

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_NEG = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [SH-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [3:0]       flag_q, flag_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] res;
  logic             carry;
  logic             ovf;
  logic [SH-1:0]    amt_in;

  assign amt_in = bus.control[3] ? bus.in2[SH-1:0] : bus.shamt;

  // Single-cycle datapath on the latched operands.
  always_comb begin
    res   = a_q;
    carry = 1'b0;
    ovf   = 1'b0;
    case (op_q)
      OP_ADD: begin
        {carry, res} = {1'b0, a_q} + {1'b0, b_q};
        ovf = (a_q[MSB] == b_q[MSB]) && (res[MSB] != a_q[MSB]);
      end
      OP_NEG: begin
        res = ~b_q + ONE;
        ovf = (b_q == MIN_NEG);
      end
      OP_SUB: begin
        res   = a_q - b_q;
        carry = (a_q >= b_q);
        ovf   = (a_q[MSB] != b_q[MSB]) && (res[MSB] != a_q[MSB]);
      end
      OP_AND: res = a_q & b_q;
      OP_XOR: res = a_q ^ b_q;
`ifdef ALU_SEQ_BARREL_EN
      OP_SLL: res = a_q << cnt_q;
      OP_SRL: res = a_q >> cnt_q;
      OP_SRA: res = $signed(a_q) >>> cnt_q;
`endif
      default: res = a_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    flag_d  = flag_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d   = bus.in1;
          b_d   = bus.in2;
          op_d  = bus.control[2:0];
          cnt_d = amt_in;
`ifdef ALU_SEQ_BARREL_EN
          state_d = EXEC;
`else
          // 101/110/111 are the shift opcodes
          state_d = (bus.control[2] && (bus.control[1:0] != 2'b00)) ? SHIFT : EXEC;
`endif
        end
      end
      EXEC: begin
        out_d   = res;
        flag_d  = {ovf, carry, res[MSB], (res == '0)};
        done_d  = 1'b1;
        state_d = IDLE;
      end
      SHIFT: begin
        if (cnt_q == '0) begin
          out_d   = a_q;
          flag_d  = {2'b00, a_q[MSB], (a_q == '0)};
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          case (op_q)
            OP_SLL:  a_d = {a_q[MSB-1:0], 1'b0};
            OP_SRL:  a_d = {1'b0, a_q[MSB:1]};
            default: a_d = {a_q[MSB], a_q[MSB:1]};
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      flag_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      flag_q  <= flag_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.out  = out_q;
  assign bus.flag = flag_q;

endmodule
